// File: rtl/audio_pwm_player.sv
// audio_pwm_player: FIFO-buffered PCM playback, one sample per divider tick, rendered as 8-bit PWM
module audio_pwm_player #(
    parameter int SAMPLE_DIV = 2267,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic                          aud_pwm_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fill_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] div_cnt;
    logic [7:0]    pwm_cnt, pending, duty;
    logic          push, pop, tick, empty;

    assign sample_ready_out = count != FULL_CNT;
    assign fill_out         = count;
    assign empty            = count == '0;
    assign push             = sample_valid_in && sample_ready_out;
    assign tick             = enable_in && div_cnt == DIV_LAST;
    // pop decision uses the registered count, so a same-cycle push is never read through
    assign pop              = tick && !empty;

    // sample storage; contents need no reset since the pointers gate every read
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // sample-period divider, parked at zero while playback is stopped
    always_ff @(posedge clk_in) begin
        if (rst_in || !enable_in) div_cnt <= '0;
        else                      div_cnt <= tick ? '0 : div_cnt + DW'(1);
    end

    // sample hand-off: pop into pending, move pending to duty only at a PWM period boundary
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending      <= 8'h80;
            duty         <= 8'h80;
            underrun_out <= 1'b0;
        end else begin
            if (pop) pending <= mem[rd_ptr];
            if (tick && empty) underrun_out <= 1'b1;
            if (enable_in && pwm_cnt == 8'hFF) duty <= pending;
        end
    end

    // PWM counter and registered comparator output
    always_ff @(posedge clk_in) begin
        if (rst_in || !enable_in) begin
            pwm_cnt     <= 8'h00;
            aud_pwm_out <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt + 8'd1;
            aud_pwm_out <= pwm_cnt < duty;
        end
    end
endmodule

// File: tb/tb_audio_pwm_player.sv
// tb_audio_pwm_player: vector table, directed playback sequences and a randomized model comparison
module tb_audio_pwm_player;
    localparam int SAMPLE_DIV = 300;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, valid = 1'b0;
    logic [7:0] sin = 8'h00;
    logic       ready, aud, und;
    logic [2:0] fill;
    int         total = 0, bad = 0;

    logic [7:0] q[$];
    int         m_run = 0;
    logic [7:0] m_pend = 8'h80, m_duty = 8'h80;
    logic       m_und = 1'b0, m_aud = 1'b0;

    typedef struct {
        logic       rst, en, valid;
        logic [7:0] s;
        logic [2:0] fill;
        logic       ready, und, aud;
    } vec_t;

    audio_pwm_player #(.SAMPLE_DIV(SAMPLE_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(en), .sample_in(sin),
        .sample_valid_in(valid), .sample_ready_out(ready), .aud_pwm_out(aud),
        .underrun_out(und), .fill_out(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: a playing run of n enabled cycles ticks when n mod SAMPLE_DIV hits the end
    // of a period, and the PWM phase is simply n mod 256.
    task automatic model_edge();
        logic [7:0] np;
        bit tk, pu;
        int pc;
        if (rst) begin
            q.delete();
            m_run = 0; m_pend = 8'h80; m_duty = 8'h80; m_und = 0; m_aud = 0;
        end else begin
            tk = en && (m_run % SAMPLE_DIV == SAMPLE_DIV - 1);
            pu = valid && q.size() < FIFO_DEPTH;
            pc = m_run % 256;
            np = m_pend;
            if (tk) begin
                if (q.size() > 0) np = q.pop_front();
                else m_und = 1;
            end
            if (pu) q.push_back(sin);
            m_aud = en && (pc < int'(m_duty));
            if (en && pc == 255) m_duty = m_pend;
            m_pend = np;
            m_run = en ? m_run + 1 : 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step();
            if (aud === 1'b1) hi++;
        end
    endtask

    task automatic do_reset();
        rst = 1; en = 0; valid = 0;
        steps(2);
        rst = 0;
    endtask

    task automatic push(input logic [7:0] v);
        valid = 1; sin = v;
        step();
        valid = 0;
    endtask

    initial begin
        vec_t tv[8];
        int hi, vrate;
        tv[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 8'h10, 3'd1, 1'b1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b0, 1'b1, 8'h20, 3'd2, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b0, 1'b1, 8'h30, 3'd3, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b0, 1'b1, 8'h40, 3'd4, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1'b0, 1'b0, 1'b1, 8'h50, 3'd4, 1'b0, 1'b0, 1'b0};
        tv[7] = '{1'b0, 1'b0, 1'b1, 8'h50, 3'd4, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            rst = tv[i].rst; en = tv[i].en; valid = tv[i].valid; sin = tv[i].s;
            step();
            chk($sformatf("vec%0d fill", i), fill, tv[i].fill);
            chk($sformatf("vec%0d ready", i), ready, tv[i].ready);
            chk($sformatf("vec%0d underrun", i), und, tv[i].und);
            chk($sformatf("vec%0d aud", i), aud, tv[i].aud);
        end

        // 0x50 stays offered; first tick frees a slot, next edge accepts it
        en = 1;
        steps(SAMPLE_DIV - 1);
        chk("prefill pre-tick fill", fill, 4);
        chk("prefill pre-tick underrun", und, 0);
        step();
        chk("prefill pop fill", fill, 3);
        chk("prefill pop ready", ready, 1);
        step();
        chk("prefill held push fill", fill, 4);
        chk("prefill held push ready", ready, 0);
        valid = 0;

        // playback duty 0x40: reset duty period first, then the loaded sample
        do_reset();
        push(8'h40);
        en = 1;
        steps(256);
        count_high(256, hi);
        chk("play reset duty high", hi, 128);
        count_high(256, hi);
        chk("play 0x40 high", hi, 64);
        chk("play underrun after drain", und, 1);

        // extremes: a never-high period followed directly by a 255/256 period
        do_reset();
        push(8'h00);
        push(8'hFF);
        en = 1;
        steps(512);
        count_high(256, hi);
        chk("extreme 0x00 high", hi, 0);
        count_high(256, hi);
        chk("extreme 0xFF high", hi, 255);
        en = 0;
        step();
        chk("disable aud", aud, 0);
        chk("disable fill", fill, 0);

        // underrun from an empty FIFO, with the reset duty still playing
        do_reset();
        en = 1;
        steps(SAMPLE_DIV - 1);
        chk("underrun before tick", und, 0);
        step();
        chk("underrun at tick", und, 1);
        steps(212);
        count_high(256, hi);
        chk("underrun reset duty high", hi, 128);
        chk("underrun sticky", und, 1);

        // reset mid-playback discards buffered samples and clears underrun
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        en = 1;
        steps(1250);
        chk("midplay underrun set", und, 1);
        push(8'h44); push(8'h55);
        chk("midplay fill", fill, 2);
        rst = 1;
        step();
        rst = 0;
        chk("midplay reset fill", fill, 0);
        chk("midplay reset aud", aud, 0);
        chk("midplay reset underrun", und, 0);
        chk("midplay reset ready", ready, 1);
        steps(SAMPLE_DIV - 1);
        chk("midplay pre-tick underrun", und, 0);
        step();
        chk("midplay tick underrun", und, 1);

        // randomized traffic against the reference model
        rst = 1; valid = 0;
        step();
        rst = 0; en = 1; vrate = 100;
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                en = !en;
                vrate = $urandom_range(0, 1000);
            end
            rst = $urandom_range(0, 3999) == 0;
            valid = $urandom_range(0, 999) < vrate;
            sin = 8'($urandom_range(0, 255));
            step();
            chk($sformatf("rand%0d fill", c), fill, q.size());
            chk($sformatf("rand%0d ready", c), ready, q.size() < FIFO_DEPTH);
            chk($sformatf("rand%0d underrun", c), und, m_und);
            chk($sformatf("rand%0d aud", c), aud, m_aud);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_pwm_player.md
# audio_pwm_player

Playback back end of the audio path. It accepts 8-bit unsigned PCM samples from the SD-card sector reader over a valid/ready stream and buffers them in a small FIFO. It releases one sample per sample period from a programmable clock divider and renders it as glitch-free 8-bit PWM on the board audio pin. Upstream can prefill while playback is disabled, and buffer starvation is reported as a sticky underrun flag.

## Interface
Parameters:
- SAMPLE_DIV, 2267: clock cycles per sample period (100 MHz / 2267 ≈ 44.1 kHz); must be ≥ 2.
- FIFO_DEPTH, 16: sample buffer entries; power of two, ≥ 2.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- enable_in  input  1  play enable (play_audio); low stops output and the sample clock.
- sample_in  input  8  unsigned PCM sample; 0x80 is silence.
- sample_valid_in  input  1  upstream offers sample_in this cycle.
- sample_ready_out  output  1  block accepts a sample this cycle; equals !full, combinational from fill count.
- aud_pwm_out  output  1  registered PWM audio output.
- underrun_out  output  1  sticky; set when a sample was due but the FIFO was empty.
- fill_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Push.** A sample is pushed when sample_valid_in && sample_ready_out.
  - Push happens regardless of enable_in, so prefill works.
  - When full, ready is low and upstream must hold its data.
- **Divider.** div_cnt counts 0..SAMPLE_DIV-1 while enable_in is high.
  - tick is asserted on the cycle div_cnt == SAMPLE_DIV-1, after which the count wraps to 0.
  - With enable_in low, div_cnt is held at 0 and no tick occurs.
- **Pop.**
  - On tick with the FIFO non-empty: pop the head into the pending register.
  - On tick with the FIFO empty: set underrun_out and leave pending unchanged, so the last sample repeats.
  - No read-through: a sample pushed in the same cycle as a tick on an empty FIFO is not popped by that tick.
  - A simultaneous push and pop leaves fill_out unchanged.
- **PWM.** pwm_cnt is 8 bits and increments 0..255, wrapping to 0, while enable_in is high.
  - Each cycle aud_pwm_out <= (pwm_cnt < duty), giving duty/256 high time. Duty 0x00 is never high; 0xFF is high 255 of 256 cycles.
- **Glitch-free update.** duty <= pending only on the cycle pwm_cnt == 255, so a PWM period never mixes two duties.
  - If more than one tick falls inside one PWM period (SAMPLE_DIV < 256), only the latest pending value is used.
- **Disable.** With enable_in low:
  - pwm_cnt is held at 0 and aud_pwm_out is driven 0.
  - FIFO contents, pending, duty and underrun_out are retained.
- **Reset.** rst_in clears the FIFO pointers and count, div_cnt and pwm_cnt; sets pending and duty to 0x80; clears underrun_out and aud_pwm_out.
  - Reset mid-playback discards all buffered samples.
- **Clearing underrun.** underrun_out is cleared only by rst_in.

## Timing
- Reset values:
  - aud_pwm_out 0, underrun_out 0, fill_out 0.
  - sample_ready_out 1 from the first cycle after reset.
- Push accepted at edge t: fill_out increments at t+1, and sample_ready_out falls at t+1 if the push made the FIFO full.
- First tick: enable_in sampled high at edge e gives tick during cycle e+SAMPLE_DIV-1. Ticks then repeat every SAMPLE_DIV cycles.
- Pop on the tick edge: pending valid next cycle.
- Duty load: on the next edge where pwm_cnt == 255.
- aud_pwm_out reflects the new duty from the following cycle; that PWM period starts with pwm_cnt = 0.
- Underrun: underrun_out rises on the cycle after the edge ending the offending tick cycle.
- enable_in falling: aud_pwm_out is 0 from the next cycle.
- enable_in rising: the PWM period restarts from pwm_cnt = 0.

## Test plan
Run with SAMPLE_DIV=300 and FIFO_DEPTH=4 unless stated.
- **Reset:** assert rst_in 2 cycles, enable_in 0 -> aud_pwm_out 0, underrun_out 0, fill_out 0, sample_ready_out 1.
- **Prefill/backpressure:** enable 0, drive valid with 0x10,0x20,0x30,0x40,0x50 back-to-back -> fill_out reaches 4, sample_ready_out 0, 0x50 held and accepted only after a pop. Then enable -> fill_out drops to 3 one cycle after the first tick.
- **Playback duty:** push 0x40, enable -> after the first tick and the next pwm_cnt wrap, aud_pwm_out is high exactly 64 of every 256 cycles.
- **Extremes:** push 0x00 then 0xFF -> one full period never high, then 255 of 256 cycles high, with no partial period at the switch.
- **Underrun:** enable with the FIFO empty from reset -> underrun_out rises at cycle 301 and stays high; aud_pwm_out is high 128/256, from the reset duty 0x80.
- **Reset mid-play:** fill 3 samples, enable, assert rst_in during playback -> fill_out 0, aud_pwm_out 0 next cycle, underrun_out 0, and the next tick with an empty FIFO sets underrun_out.
